// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, constants and state encoding
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    // Truncates to 4 bits so invalid digits still produce a defined value.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_NINE - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder cell
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] bin_sum;
    logic [4:0] adj_sum;

    // A binary carry always implies a sum above 9, so one compare covers both.
    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        cout    = (bin_sum > 5'd9);
        adj_sum = cout ? (bin_sum + 5'd6) : bin_sum;
        sum     = adj_sum[3:0];
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial BCD add/subtract with sign-magnitude result
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                ovf,
    output logic                neg,
    output logic                err
);

    localparam int            W    = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, res_q, res_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q, sub_q;
    logic            busy_q, done_q, ovf_q, neg_q, err_q;

    logic [W-1:0]    b_load;
    logic            err_in;
    bcd_digit_t      cell_a, cell_b, cell_sum;
    logic            cell_cout;

    always_comb begin
        b_load = '0;
        err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            b_load[4*i +: 4] = sub ? nines_comp(b[4*i +: 4]) : b[4*i +: 4];
            if ((a[4*i +: 4] > BCD_NINE) || (b[4*i +: 4] > BCD_NINE))
                err_in = 1'b1;
        end
    end

    // FIX reuses the cell to form the ten's complement of the partial result.
    always_comb begin
        cell_a = a_q[3:0];
        cell_b = b_q[3:0];
        if (state_q == FIX) begin
            cell_a = nines_comp(res_q[3:0]);
            cell_b = 4'd0;
        end
    end

    bcd_digit_add u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    generate
        if (DIGITS > 1) begin : g_multi
            assign res_d = {cell_sum, res_q[W-1:4]};
        end else begin : g_single
            assign res_d = cell_sum;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        sub_q   <= sub;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        err_q   <= err_in;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        neg_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    res_q   <= res_d;
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        if (!sub_q) begin
                            ovf_q   <= cell_cout;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (cell_cout) begin
                            neg_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // No end-around carry: A < B, so complement back to B-A.
                            neg_q   <= 1'b1;
                            carry_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    res_q   <= res_d;
                    carry_q <= cell_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign ovf    = ovf_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - scoreboard bench for bcd_serial_addsub (DIGITS=4)
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, ovf, neg, err;
    logic [15:0] result;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] r;
        logic        ovf;
        logic        neg;
        logic        err;
        logic        chk_r;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .neg    (neg),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [15:0] er, input logic eo, input logic en,
                          input logic ee, input logic ec, input int lat);
        exp_t e;
        a = av; b = bv; sub = sv; start = 1'b1;
        e.r = er; e.ovf = eo; e.neg = en; e.err = ee; e.chk_r = ec; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, input string tag, input logic post_chk);
        int   cyc = 1;
        int   bc  = 0;
        exp_t e;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bc++;
            if (cyc == poke_at) begin
                a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            check({tag, "_timeout"}, {31'd0, done}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (busy === 1'b1) bc++;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_busy_cycles"}, bc, e.lat);
        if (e.chk_r) check({tag, "_result"}, {16'd0, result}, {16'd0, e.r});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
        check({tag, "_neg"}, {31'd0, neg}, {31'd0, e.neg});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        if (post_chk) begin
            @(negedge clk);
            check({tag, "_after_done"}, {30'd0, done, busy}, 32'd0);
        end
    endtask

    initial begin
        int dones;

        repeat (3) @(negedge clk);
        check("reset_flags", {28'd0, busy, done, ovf, neg, err} , 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "add_1234_5678", 1'b1);

        launch(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "add_ovf", 1'b1);

        launch(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "sub_pos", 1'b1);

        launch(16'h0420, 16'h0420, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "sub_equal", 1'b0);

        // start raised in the DONE cycle must be ignored, then taken in IDLE
        a = 16'h0011; b = 16'h0022; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", {31'd0, busy}, 32'd0);
        launch(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "idle_start_taken", 1'b1);

        launch(16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0, 1'b1, 9);
        wait_done(0, "sub_neg", 1'b1);

        launch(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(2, "busy_start", 1'b1);

        launch(16'h00A1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        wait_done(0, "invalid_digit", 1'b1);

        // abort in the third ADD cycle
        launch(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_flags", {28'd0, busy, done, ovf, neg, err}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        sb.delete();
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);

        launch(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        wait_done(0, "after_abort", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
